// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, registered valid/ready output to decode,
// jump/branch/call/ret redirects with a circular return-address stack, halt detection.
module fetch_unit #(
  parameter int                PC_W      = 16,
  parameter int                INSN_W    = 16,
  parameter int                JADDR_W   = 13,
  parameter int                IMM_W     = 7,
  parameter int                RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [INSN_W-1:0] HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSN_W-1:0]  imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSN_W-1:0]  out_insn,
  output logic [PC_W-1:0]    out_pc,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jump_addr,
  input  logic               branch,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_imm,
  input  logic               call,
  input  logic               ret,
  output logic               halted,
  output logic               ras_err
);

  // state   | meaning
  // S_RUN   | fetching, PC advances on each load
  // S_HALT  | halt word seen; PC and RAS frozen until reset
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   ras [RAS_DEPTH];
  logic [PTR_W-1:0]  sp, sp_prev, sp_next;
  logic [CNT_W-1:0]  cnt;
  logic              in_run, acc, ras_empty, ras_full;
  logic              do_ret, do_call, do_jump, do_br, redirect, ld, halt_hit;
  logic [PC_W-1:0]   redirect_pc;

  assign imem_addr = pc;
  assign in_run    = (state == S_RUN);
  assign acc       = out_valid & out_ready;
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));
  assign sp_prev   = (sp == '0) ? PTR_W'(RAS_DEPTH - 1) : sp - PTR_W'(1);
  assign sp_next   = (sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp + PTR_W'(1);

  // Redirect priority: ret > call > jump > taken branch.
  assign do_ret   = in_run & acc & ret;
  assign do_call  = in_run & acc & call & ~ret;
  assign do_jump  = in_run & acc & jump & ~ret & ~call;
  assign do_br    = in_run & acc & branch & branch_taken & ~ret & ~call & ~jump;
  assign redirect = do_ret | do_call | do_jump | do_br;
  assign ld       = in_run & (~out_valid | acc) & ~redirect;
  assign halt_hit = ld & (imem_data == HALT_WORD);

  always_comb begin
    redirect_pc = pc;
    if (do_ret)
      redirect_pc = ras_empty ? RESET_PC : ras[sp_prev];
    else if (do_call || do_jump)
      redirect_pc = PC_W'(jump_addr);
    else if (do_br)
      redirect_pc = PC_W'(branch_imm);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_RUN && halt_hit) state_nxt = S_HALT;
  end

  always_comb begin
    halted = (state == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_pc    <= '0;
      sp        <= '0;
      cnt       <= '0;
      ras_err   <= 1'b0;
    end else if (redirect) begin
      pc        <= redirect_pc;
      out_valid <= 1'b0;
      if (do_ret) begin
        if (ras_empty) begin
          ras_err <= 1'b1;
        end else begin
          sp  <= sp_prev;
          cnt <= cnt - CNT_W'(1);
        end
      end
      if (do_call) begin
        sp <= sp_next;
        if (!ras_full) cnt <= cnt + CNT_W'(1);
      end
    end else if (ld) begin
      if (halt_hit) begin
        out_valid <= 1'b0;
      end else begin
        out_insn  <= imem_data;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + PC_W'(1);
      end
    end else if (acc) begin
      out_valid <= 1'b0;
    end
  end

  // Stack storage needs no reset; cnt alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_call) ras[sp] <= out_pc + PC_W'(1);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// a transaction-level program-flow model (expected next PC, return stack as a queue).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr, imem_data, out_insn, out_pc;
  logic        out_valid, out_ready, jump, branch, branch_taken, call, ret;
  logic [12:0] jump_addr;
  logic [6:0]  branch_imm;
  logic        halted, ras_err;

  logic [15:0] mem [0:65535];
  int vectors = 0;
  int miscompares = 0;

  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
    .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .call(call), .ret(ret), .halted(halted), .ras_err(ras_err)
  );

  task automatic fill_mem();
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (v == 16'hFFFF) v = 16'h1234;
      mem[i] = v;
    end
  endtask

  task automatic clear_inputs();
    out_ready = 1'b0; jump = 1'b0; jump_addr = '0; branch = 1'b0;
    branch_taken = 1'b0; branch_imm = '0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept words until the given PC is presented; bounded.
  task automatic run_to(input logic [15:0] target);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (out_valid === 1'b1 && out_pc === target) return;
      @(negedge clk);
    end
    vectors++; miscompares++;
    $display("FAIL run_to timeout: out_pc=%h, required %h", out_pc, target);
  endtask

  // kind: 0 jump, 1 branch taken, 2 call, 3 ret; returns out_valid in the bubble cycle.
  task automatic fire(input int kind, input logic [15:0] addr, output logic bubble_valid);
    out_ready = 1'b1;
    case (kind)
      0: begin jump = 1'b1; jump_addr = addr[12:0]; end
      1: begin branch = 1'b1; branch_taken = 1'b1; branch_imm = addr[6:0]; end
      2: begin call = 1'b1; jump_addr = addr[12:0]; end
      default: ret = 1'b1;
    endcase
    @(negedge clk);
    jump = 1'b0; branch = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
    bubble_valid = out_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #12;
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_insn !== 16'h0 || imem_addr !== 16'h0 ||
        halted !== 1'b0 || ras_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: v=%b pc=%h insn=%h addr=%h halt=%b err=%b, required all zero",
               out_valid, out_pc, out_insn, imem_addr, halted, ras_err);
    end
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_early: out_valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0) begin
      miscompares++;
      $display("FAIL first_valid: out_valid=%b out_pc=%h, required 1/0000", out_valid, out_pc);
    end
  endtask

  task automatic test_straight();
    logic [15:0] words [4];
    fill_mem();
    for (int i = 0; i < 4; i++) begin
      words[i] = 16'h1000 + 16'(i) * 16'h0111;
      mem[i] = words[i];
    end
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_insn !== words[i]) begin
        miscompares++;
        $display("FAIL straight[%0d]: v=%b pc=%h insn=%h, required 1/%h/%h",
                 i, out_valid, out_pc, out_insn, 16'(i), words[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_to(16'h2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 16'h2 || out_insn !== mem[2] || imem_addr !== 16'h3) begin
        miscompares++;
        $display("FAIL stall[%0d]: v=%b pc=%h insn=%h addr=%h, required 1/0002/%h/0003",
                 i, out_valid, out_pc, out_insn, imem_addr, mem[2]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 16'h3) begin
      miscompares++;
      $display("FAIL stall_release: v=%b pc=%h, required 1/0003", out_valid, out_pc);
    end
  endtask

  task automatic test_jump();
    logic bv;
    do_reset();
    run_to(16'h5);
    fire(0, 16'h0040, bv);
    vectors++;
    if (bv !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h0040 || out_insn !== mem[16'h40]) begin
      miscompares++;
      $display("FAIL jump: bubble_v=%b v=%b pc=%h, required 0/1/0040", bv, out_valid, out_pc);
    end
  endtask

  task automatic test_branch();
    logic bv;
    do_reset();
    run_to(16'h8);
    branch = 1'b1; branch_taken = 1'b0; branch_imm = 7'h12;
    @(negedge clk);
    branch = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 16'h9) begin
      miscompares++;
      $display("FAIL branch_not_taken: v=%b pc=%h, required 1/0009", out_valid, out_pc);
    end
    fire(1, 16'h0012, bv);
    vectors++;
    if (bv !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h0012) begin
      miscompares++;
      $display("FAIL branch_taken: bubble_v=%b v=%b pc=%h, required 0/1/0012", bv, out_valid, out_pc);
    end
  endtask

  task automatic test_ras();
    logic bv;
    logic [15:0] rets [5];
    do_reset();
    run_to(16'h2);
    fire(2, 16'h0010, bv);
    fire(2, 16'h0020, bv);
    fire(3, 16'h0, bv);
    vectors++;
    if (bv !== 1'b0 || out_pc !== 16'h0011) begin
      miscompares++;
      $display("FAIL ras_ret1: bubble_v=%b pc=%h, required 0/0011", bv, out_pc);
    end
    fire(3, 16'h0, bv);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0003) begin
      miscompares++;
      $display("FAIL ras_ret2: v=%b pc=%h, required 1/0003", out_valid, out_pc);
    end
    // Five calls overflow a 4-deep stack; the oldest return (0x0001) is lost.
    do_reset();
    run_to(16'h0);
    for (int i = 1; i <= 5; i++) fire(2, 16'(i) * 16'h0100, bv);
    rets = '{16'h0401, 16'h0301, 16'h0201, 16'h0101, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      fire(3, 16'h0, bv);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== rets[i] || ras_err !== (i == 4)) begin
        miscompares++;
        $display("FAIL ras_overflow_ret[%0d]: v=%b pc=%h err=%b, required 1/%h/%b",
                 i, out_valid, out_pc, ras_err, rets[i], (i == 4));
      end
    end
  endtask

  task automatic test_halt();
    fill_mem();
    mem[4] = 16'hFFFF;
    do_reset();
    run_to(16'h3);
    @(negedge clk);
    vectors++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 16'h4) begin
      miscompares++;
      $display("FAIL halt_entry: halted=%b v=%b addr=%h, required 1/0/0004", halted, out_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    vectors++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 16'h4) begin
      miscompares++;
      $display("FAIL halt_hold: halted=%b v=%b addr=%h, required 1/0/0004", halted, out_valid, imem_addr);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (halted !== 1'b0 || imem_addr !== 16'h0) begin
      miscompares++;
      $display("FAIL halt_async_reset: halted=%b addr=%h, required 0/0000", halted, imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    mem[4] = 16'h0004;
    // Reset while stalled on a valid word.
    do_reset();
    run_to(16'h2);
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_insn !== 16'h0 || imem_addr !== 16'h0) begin
      miscompares++;
      $display("FAIL stall_async_reset: v=%b pc=%h insn=%h addr=%h, required all zero",
               out_valid, out_pc, out_insn, imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] stack [$];
    logic        exp_err, expect_bubble, expect_valid;
    int          bad_pc;
    fill_mem();
    do_reset();
    exp_pc = 16'h0; exp_err = 1'b0; expect_bubble = 1'b0; expect_valid = 1'b1; bad_pc = 0;
    stack.delete();
    @(negedge clk);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ((expect_bubble && out_valid !== 1'b0) || (expect_valid && out_valid !== 1'b1)) begin
        vectors++; miscompares++;
        $display("FAIL rand_valid cyc %0d: out_valid=%b, required %b", cyc, out_valid, expect_valid);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        if (out_pc !== exp_pc || out_insn !== mem[exp_pc]) begin
          miscompares++;
          $display("FAIL rand_word cyc %0d: pc=%h insn=%h, required %h/%h",
                   cyc, out_pc, out_insn, exp_pc, mem[exp_pc]);
          if (++bad_pc > 5) break;
        end
      end
      vectors++;
      if (ras_err !== exp_err || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_flags cyc %0d: ras_err=%b halted=%b, required %b/0", cyc, ras_err, halted, exp_err);
      end
      out_ready    = ($urandom_range(0, 3) != 0);
      ret          = ($urandom_range(0, 9) == 0);
      call         = ($urandom_range(0, 7) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      branch       = ($urandom_range(0, 3) == 0);
      branch_taken = 1'($urandom);
      jump_addr    = 13'($urandom);
      branch_imm   = 7'($urandom);
      expect_bubble = 1'b0;
      expect_valid  = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        if (ret) begin
          if (stack.size() == 0) begin exp_pc = 16'h0; exp_err = 1'b1; end
          else exp_pc = stack.pop_back();
          expect_bubble = 1'b1;
        end else if (call) begin
          stack.push_back(exp_pc + 16'h1);
          if (stack.size() > 4) void'(stack.pop_front());
          exp_pc = {3'b000, jump_addr};
          expect_bubble = 1'b1;
        end else if (jump) begin
          exp_pc = {3'b000, jump_addr};
          expect_bubble = 1'b1;
        end else if (branch && branch_taken) begin
          exp_pc = {9'h000, branch_imm};
          expect_bubble = 1'b1;
        end else begin
          exp_pc = exp_pc + 16'h1;
        end
        if (expect_bubble) expect_valid = 1'b0;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    fill_mem();
    clear_inputs();
    test_reset();
    test_straight();
    test_backpressure();
    test_jump();
    test_branch();
    test_ras();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
